// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RISC-V datapath: sequences fetch/decode/
// execute/memory/writeback, stalls on mem_ready, counts retirements, traps on illegal ops.
module multicycle_control_fsm #(
  parameter logic [3:0] AND_OP = 4'b0000,
  parameter logic [3:0] OR_OP  = 4'b0001,
  parameter logic [3:0] ADD_OP = 4'b0010,
  parameter logic [3:0] SUB_OP = 4'b0110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic        illegal,
  output logic [3:0]  state_dbg,
  output logic [31:0] instr_retired
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd15
  } ctrlState;

  ctrlState    stateReg, stateNext;
  logic        illegalReg;
  logic [31:0] instrRetiredReg;
  logic        pcUpdate, branch, retire, memReady, aluFunctLegal;

  // While reset is held the FETCH outputs must look like a stalled access.
  assign memReady      = mem_ready & rst_n;
  assign aluFunctLegal = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

  function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic isSub);
    case (f3)
      3'b110:  aluDecode = OR_OP;
      3'b111:  aluDecode = AND_OP;
      default: aluDecode = isSub ? SUB_OP : ADD_OP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg        <= FETCH;
      illegalReg      <= 1'b0;
      instrRetiredReg <= 32'd0;
    end else begin
      stateReg <= stateNext;
      if (stateNext == TRAP) illegalReg <= 1'b1;
      if (retire) instrRetiredReg <= instrRetiredReg + 32'd1;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ADD_OP;
    case (stateReg)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (memReady) begin
          IRWrite   = 1'b1;
          pcUpdate  = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: stateNext = MEMADR;
          OP_RTYPE:          stateNext = aluFunctLegal ? EXECR : TRAP;
          OP_ITYPE:          stateNext = aluFunctLegal ? EXECI : TRAP;
          OP_BRANCH:         stateNext = (funct3 == 3'b000) ? BEQ : TRAP;
          OP_JAL:            stateNext = JAL;
          default:           stateNext = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        stateNext = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (memReady) stateNext = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        stateNext = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (memReady) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = aluDecode(funct3, funct7b5);
        stateNext  = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = aluDecode(funct3, 1'b0);
        stateNext  = ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        stateNext = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = SUB_OP;
        branch     = 1'b1;
        retire     = 1'b1;
        stateNext  = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        stateNext = ALUWB;
      end
      TRAP:    stateNext = TRAP;
      default: stateNext = TRAP;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite       = pcUpdate | (branch & zero);
  assign illegal       = illegalReg;
  assign state_dbg     = stateReg;
  assign instr_retired = instrRetiredReg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm with hand-computed expectations.
module tb_multicycle_control_fsm;
  logic        clk = 1'b0;
  logic        rst_n, funct7b5, zero, memReady;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0]  ALUControl, stateDbg;
  logic [31:0] instrRetired;
  int assertCount = 0;
  int failCount   = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(memReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal),
    .state_dbg(stateDbg), .instr_retired(instrRetired)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Step past the next rising edge; inputs are then changed well away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    rst_n = 1'b0; memReady = 1'b1; zero = 1'b0;
    setInstr(7'd0, 3'd0, 1'b0);
    tick(); tick(); #1;
    checkVal("rst_state", stateDbg, 0);
    checkVal("rst_pcwrite", PCWrite, 0);
    checkVal("rst_irwrite", IRWrite, 0);
    checkVal("rst_illegal", illegal, 0);
    checkVal("rst_retired", instrRetired, 0);
    rst_n = 1'b1; #1;
    checkVal("rel_irwrite", IRWrite, 1);
    checkVal("rel_pcwrite", PCWrite, 1);

    // R-type sub
    setInstr(7'b0110011, 3'b000, 1'b1);
    tick(); #1;
    checkVal("sub_decode", stateDbg, 1);
    checkVal("sub_dec_srca", ALUSrcA, 1);
    checkVal("sub_dec_regw", RegWrite, 0);
    tick(); #1;
    checkVal("sub_execr", stateDbg, 6);
    checkVal("sub_aluctl", ALUControl, 4'b0110);
    checkVal("sub_ex_srca", ALUSrcA, 2);
    checkVal("sub_ex_regw", RegWrite, 0);
    tick(); #1;
    checkVal("sub_aluwb", stateDbg, 8);
    checkVal("sub_wb_regw", RegWrite, 1);
    tick(); #1;
    checkVal("sub_fetch", stateDbg, 0);
    checkVal("sub_retired", instrRetired, 1);

    // lw with three stall cycles in MEMREAD
    setInstr(7'b0000011, 3'b010, 1'b0);
    tick(); #1;
    checkVal("lw_decode", stateDbg, 1);
    checkVal("lw_immsrc", ImmSrc, 0);
    tick(); #1;
    checkVal("lw_memadr", stateDbg, 2);
    memReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      memReady = (i == 3);
      #1;
      checkVal($sformatf("lw_memread%0d", i), stateDbg, 3);
      checkVal($sformatf("lw_adrsrc%0d", i), AdrSrc, 1);
    end
    tick(); #1;
    checkVal("lw_memwb", stateDbg, 4);
    checkVal("lw_resultsrc", ResultSrc, 1);
    checkVal("lw_regw", RegWrite, 1);
    tick(); #1;
    checkVal("lw_fetch", stateDbg, 0);
    checkVal("lw_retired", instrRetired, 2);

    // beq: PCWrite follows zero
    setInstr(7'b1100011, 3'b000, 1'b0);
    tick(); #1;
    checkVal("beq_immsrc", ImmSrc, 2);
    tick(); zero = 1'b1; #1;
    checkVal("beq_state", stateDbg, 9);
    checkVal("beq_aluctl", ALUControl, 4'b0110);
    checkVal("beq_pcw_z1", PCWrite, 1);
    zero = 1'b0; #1;
    checkVal("beq_pcw_z0", PCWrite, 0);
    tick(); #1;
    checkVal("beq_fetch", stateDbg, 0);
    checkVal("beq_retired", instrRetired, 3);

    // sw with one stall cycle in MEMWRITE
    setInstr(7'b0100011, 3'b010, 1'b0);
    tick(); #1;
    checkVal("sw_immsrc", ImmSrc, 1);
    tick(); memReady = 1'b0;
    tick(); #1;
    checkVal("sw_memwrite", stateDbg, 5);
    checkVal("sw_mwrite", MemWrite, 1);
    tick(); memReady = 1'b1; #1;
    checkVal("sw_hold", stateDbg, 5);
    checkVal("sw_hold_mw", MemWrite, 1);
    tick(); #1;
    checkVal("sw_fetch", stateDbg, 0);
    checkVal("sw_retired", instrRetired, 4);

    // jal
    setInstr(7'b1101111, 3'b000, 1'b0);
    tick(); #1;
    checkVal("jal_immsrc", ImmSrc, 3);
    tick(); #1;
    checkVal("jal_state", stateDbg, 10);
    checkVal("jal_pcwrite", PCWrite, 1);
    checkVal("jal_srcb", ALUSrcB, 2);
    tick(); #1;
    checkVal("jal_aluwb", stateDbg, 8);
    tick(); #1;
    checkVal("jal_retired", instrRetired, 5);

    // ori, then addi with funct7b5 set (must stay ADD)
    setInstr(7'b0010011, 3'b110, 1'b1);
    tick(); tick(); #1;
    checkVal("ori_execi", stateDbg, 7);
    checkVal("ori_aluctl", ALUControl, 4'b0001);
    checkVal("ori_srcb", ALUSrcB, 1);
    tick(); tick();
    setInstr(7'b0010011, 3'b000, 1'b1);
    tick(); tick(); #1;
    checkVal("addi_aluctl", ALUControl, 4'b0010);
    tick(); tick(); #1;
    checkVal("addi_retired", instrRetired, 7);

    // counter wrap
    force dut.instrRetiredReg = 32'hFFFF_FFFF;
    #1;
    release dut.instrRetiredReg;
    setInstr(7'b1100011, 3'b000, 1'b0);
    tick(); tick(); tick(); #1;
    checkVal("wrap_retired", instrRetired, 0);

    // reset while MEMWRITE stalls
    setInstr(7'b0100011, 3'b010, 1'b0);
    tick(); tick(); memReady = 1'b0;
    tick(); #1;
    checkVal("rstmw_state", stateDbg, 5);
    rst_n = 1'b0;
    tick(); #1;
    checkVal("rstmw_fetch", stateDbg, 0);
    checkVal("rstmw_mwrite", MemWrite, 0);
    checkVal("rstmw_irwrite", IRWrite, 0);
    rst_n = 1'b1; memReady = 1'b1;

    // illegal funct3 on I-type traps, sticky until reset
    setInstr(7'b0010011, 3'b001, 1'b0);
    tick(); tick(); #1;
    checkVal("trap_state", stateDbg, 15);
    checkVal("trap_illegal", illegal, 1);
    checkVal("trap_pcwrite", PCWrite, 0);
    tick(); tick(); #1;
    checkVal("trap_sticky", illegal, 1);
    checkVal("trap_hold", stateDbg, 15);
    rst_n = 1'b0;
    tick(); #1;
    checkVal("trap_clr_illegal", illegal, 0);
    checkVal("trap_clr_state", stateDbg, 0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
